bitty_fetch: RTL and testbench

Instruction sequencer that drives the bitty CPU control FSM from the issuing side. It holds the program counter and fetches 16-bit instructions from instruction memory over a req/valid handshake. It presents each instruction on d_inst, pulses run, and waits for done. It then advances the PC sequentially, or to a branch target for format-2'b10 instructions.

---
 rtl/bitty_pkg.sv | 30 +++
 rtl/bitty_next_pc.sv | 29 ++
 rtl/bitty_fetch.sv | 91 +++++++++
 tb/tb_bitty_fetch.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bitty_pkg.sv
// Shared definitions for the bitty instruction sequencer: formats, compare codes,
// instruction field positions and the fetch state encoding.
package bitty_pkg;

  localparam logic [1:0] FMT_REG = 2'b00;
  localparam logic [1:0] FMT_IMM = 2'b01;
  localparam logic [1:0] FMT_BR  = 2'b10;

  localparam logic [1:0] CMP_EQ = 2'b00;
  localparam logic [1:0] CMP_GT = 2'b01;
  localparam logic [1:0] CMP_LT = 2'b10;

  // Branch condition code that no compare result can match.
  localparam logic [1:0] COND_NEVER = 2'b11;

  localparam int unsigned IMM_MSB  = 12;
  localparam int unsigned IMM_LSB  = 4;
  localparam int unsigned COND_MSB = 3;
  localparam int unsigned COND_LSB = 2;
  localparam int unsigned IMM_W    = IMM_MSB - IMM_LSB + 1;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StIssue,
    StWait,
    StAdv
  } fetch_state_e;

endpackage

// File: rtl/bitty_next_pc.sv
// Combinational branch resolve: picks the branch immediate when a format-10 condition
// matches the ALU compare result, otherwise the sequential successor of pc.
module bitty_next_pc
  import bitty_pkg::*;
#(
  parameter int unsigned ADDR_W = 9
) (
  input  logic [15:0]       d_inst,
  input  logic [1:0]        cmp,
  input  logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] next_pc
);

  logic [1:0]       cond;
  logic [IMM_W-1:0] imm;
  logic             taken;
  logic             unused_inst;

  assign unused_inst = ^d_inst[15:IMM_MSB+1];

  always_comb begin
    cond  = d_inst[COND_MSB:COND_LSB];
    imm   = d_inst[IMM_MSB:IMM_LSB];
    taken = (d_inst[1:0] == FMT_BR) && (cond != COND_NEVER) && (cond == cmp);
    // ADDR_W >= IMM_W, so the cast only ever zero-extends.
    next_pc = taken ? ADDR_W'(imm) : pc + 1'b1;
  end

endmodule

// File: rtl/bitty_fetch.sv
// Instruction sequencer: fetches from instruction memory, issues each word to the CPU
// with a one-cycle run pulse, waits for done, then advances the program counter.
module bitty_fetch
  import bitty_pkg::*;
#(
  parameter int unsigned     ADDR_W   = 9,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              stop,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_valid,
  input  logic [15:0]       mem_rdata,
  output logic [15:0]       d_inst,
  output logic              run,
  input  logic              done,
  input  logic [1:0]        cmp,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic [15:0]       inst_count
);

  fetch_state_e      state;
  logic [ADDR_W-1:0] target;
  logic [ADDR_W-1:0] resolved_pc;

  bitty_next_pc #(
    .ADDR_W (ADDR_W)
  ) u_next_pc (
    .d_inst  (d_inst),
    .cmp     (cmp),
    .pc      (pc),
    .next_pc (resolved_pc)
  );

  assign mem_addr = pc;
  assign busy     = (state != StIdle);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= StIdle;
      pc         <= RESET_PC;
      target     <= RESET_PC;
      d_inst     <= '0;
      run        <= 1'b0;
      mem_req    <= 1'b0;
      inst_count <= '0;
    end else begin
      run <= 1'b0;
      unique case (state)
        StIdle: begin
          if (start && !stop) begin
            state   <= StFetch;
            mem_req <= 1'b1;
          end
        end
        StFetch: begin
          if (mem_valid) begin
            d_inst  <= mem_rdata;
            mem_req <= 1'b0;
            run     <= 1'b1;
            state   <= StIssue;
          end
        end
        StIssue: state <= StWait;
        StWait: begin
          // cmp is only meaningful in the CPU's final state, so resolve here.
          if (done) begin
            target     <= resolved_pc;
            inst_count <= inst_count + 1'b1;
            state      <= StAdv;
          end
        end
        StAdv: begin
          pc <= target;
          if (stop || !start) begin
            state <= StIdle;
          end else begin
            state   <= StFetch;
            mem_req <= 1'b1;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_bitty_fetch.sv
// Directed bench for bitty_fetch with a latency-programmable memory model, a
// two-cycle CPU model and a queue of predicted next-PC values.
module tb_bitty_fetch;

  localparam int unsigned AW = 9;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start;
  logic          stop;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_valid;
  logic [15:0]   mem_rdata;
  logic [15:0]   d_inst;
  logic          run;
  logic          done;
  logic [1:0]    cmp;
  logic [AW-1:0] pc;
  logic          busy;
  logic [15:0]   inst_count;

  always #5 clk = ~clk;

  bitty_fetch #(
    .ADDR_W   (AW),
    .RESET_PC ('0)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .stop       (stop),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_valid  (mem_valid),
    .mem_rdata  (mem_rdata),
    .d_inst     (d_inst),
    .run        (run),
    .done       (done),
    .cmp        (cmp),
    .pc         (pc),
    .busy       (busy),
    .inst_count (inst_count)
  );

  // Memory model: one response per request, lat cycles after req is first seen.
  logic [15:0] mem [0:511];
  int          lat;
  int          lat_cnt;
  logic        served;
  logic        mv_m;
  logic [15:0] rd_m;
  logic        force_valid;

  assign mem_valid = mv_m | force_valid;
  assign mem_rdata = force_valid ? 16'hBEEF : rd_m;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mv_m    <= 1'b0;
      rd_m    <= '0;
      served  <= 1'b0;
      lat_cnt <= 0;
    end else begin
      mv_m <= 1'b0;
      if (mem_req && !served) begin
        if (lat_cnt + 1 >= lat) begin
          mv_m    <= 1'b1;
          rd_m    <= mem[mem_addr];
          served  <= 1'b1;
          lat_cnt <= 0;
        end else begin
          lat_cnt <= lat_cnt + 1;
        end
      end
      if (!mem_req) served <= 1'b0;
    end
  end

  // CPU model: done two cycles after the run pulse.
  logic r1, r2;
  assign done = r2;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r1 <= 1'b0;
      r2 <= 1'b0;
    end else begin
      r1 <= run;
      r2 <= r1;
    end
  end

  int                checks = 0;
  int                errors = 0;
  int                cyc = 0;
  int                last_run = 0;
  logic [AW-1:0]     exp_q[$];
  logic [AW-1:0]     mpc;
  logic [15:0]       mcount;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [AW-1:0] model_next(input logic [AW-1:0] p, input logic [15:0] ins,
                                               input logic [1:0] c);
    logic [1:0] cond;
    cond = ins[3:2];
    if (ins[1:0] == 2'b10 && cond != 2'b11 && cond == c) return ins[12:4];
    return p + 9'd1;
  endfunction

  task automatic wait_run(output int req_cycles, output int valid_gap, output bit addr_ok);
    int            n;
    int            vcyc;
    bit            first;
    logic [AW-1:0] a0;
    req_cycles = 0;
    valid_gap  = -1;
    addr_ok    = 1'b1;
    vcyc       = -1;
    first      = 1'b1;
    a0         = '0;
    for (n = 0; n < 60; n++) begin
      if (run) break;
      if (mem_req) begin
        req_cycles++;
        if (first) begin
          a0    = mem_addr;
          first = 1'b0;
        end else if (mem_addr !== a0) begin
          addr_ok = 1'b0;
        end
      end
      if (mem_valid) vcyc = n;
      tick();
    end
    if (run !== 1'b1) check("run_timeout", 32'(run), 32'd1);
    else if (vcyc >= 0) valid_gap = n - vcyc;
  endtask

  task automatic wait_retire(output bit stable);
    int          n;
    logic [15:0] c0;
    logic [15:0] d0;
    c0     = inst_count;
    d0     = d_inst;
    stable = 1'b1;
    for (n = 0; n < 60; n++) begin
      if (inst_count !== c0) break;
      if (d_inst !== d0) stable = 1'b0;
      tick();
    end
    if (inst_count === c0) check("retire_timeout", 32'(inst_count), 32'(c0 + 16'd1));
    tick();
  endtask

  task automatic do_inst(input logic [1:0] c, input bit stop_mid, input bit chk_spacing,
                         input int exp_req);
    logic [15:0]   ins;
    logic [AW-1:0] np;
    int            rq;
    int            gap;
    bit            aok;
    bit            st;
    ins = mem[mpc];
    wait_run(rq, gap, aok);
    check("issue_pc", 32'(pc), 32'(mpc));
    check("issue_inst", 32'(d_inst), 32'(ins));
    if (chk_spacing) check("run_spacing", cyc - last_run, 32'd6);
    if (exp_req > 0) begin
      check("req_cycles", rq, exp_req);
      check("req_addr_stable", 32'(aok), 32'd1);
      check("run_after_valid", gap, 32'd1);
    end
    last_run = cyc;
    cmp = c;
    if (stop_mid) stop = 1'b1;
    exp_q.push_back(model_next(mpc, ins, c));
    mcount = mcount + 16'd1;
    wait_retire(st);
    check("d_inst_stable", 32'(st), 32'd1);
    np = exp_q.pop_front();
    check("retire_pc", 32'(pc), 32'(np));
    check("inst_count", 32'(inst_count), 32'(mcount));
    mpc = np;
  endtask

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 16'h0000;
    mem[3]     = 16'h0502;  // br cond EQ -> 0x050
    mem[9'h50] = 16'h0502;  // same, resolved with GT
    mem[9'h51] = 16'h050E;  // cond 11, never taken
    mem[9'h52] = 16'h1FF6;  // br cond GT -> 0x1FF
    mem[9'h1FF] = 16'h0101; // imm format, cond bits match but must not branch

    reset_n     = 1'b0;
    start       = 1'b0;
    stop        = 1'b0;
    cmp         = 2'b00;
    force_valid = 1'b0;
    lat         = 1;
    mpc         = '0;
    mcount      = '0;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    check("rst_pc", 32'(pc), 32'd0);
    check("rst_d_inst", 32'(d_inst), 32'd0);
    check("rst_run", 32'(run), 32'd0);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_inst_count", 32'(inst_count), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);

    start = 1'b1;
    do_inst(2'b00, 1'b0, 1'b0, 2);
    do_inst(2'b00, 1'b0, 1'b1, 2);
    do_inst(2'b00, 1'b0, 1'b1, 2);
    do_inst(2'b00, 1'b0, 1'b1, 2);  // taken to 0x050
    do_inst(2'b01, 1'b0, 1'b1, 2);  // not taken
    do_inst(2'b11, 1'b0, 1'b1, 2);  // cond 11 never taken
    do_inst(2'b01, 1'b0, 1'b1, 2);  // taken to 0x1FF
    do_inst(2'b00, 1'b0, 1'b1, 2);  // wrap to 0
    do_inst(2'b00, 1'b0, 1'b1, 2);

    do_inst(2'b00, 1'b1, 1'b1, 2);  // stop raised during WAIT
    for (int i = 0; i < 3; i++) begin
      check("stop_busy", 32'(busy), 32'd0);
      check("stop_mem_req", 32'(mem_req), 32'd0);
      tick();
    end

    lat  = 4;
    stop = 1'b0;
    do_inst(2'b10, 1'b0, 1'b0, 5);

    lat = 6;
    tick();
    tick();
    check("midfetch_req", 32'(mem_req), 32'd1);
    check("midfetch_addr", 32'(mem_addr), 32'(mpc));
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_busy", 32'(busy), 32'd0);
    check("async_rst_pc", 32'(pc), 32'd0);
    check("async_rst_mem_req", 32'(mem_req), 32'd0);
    start = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    force_valid = 1'b1;
    tick();
    force_valid = 1'b0;
    tick();
    check("late_valid_d_inst", 32'(d_inst), 32'd0);
    check("late_valid_busy", 32'(busy), 32'd0);
    check("late_valid_run", 32'(run), 32'd0);
    check("late_valid_mem_req", 32'(mem_req), 32'd0);
    check("late_valid_count", 32'(inst_count), 32'd0);
    check("late_valid_pc", 32'(pc), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
